// File: rtl/t_pulse_pkg.sv
// ----------------------------------------------------------------------------
// t_pulse_pkg
//   Shared types and default parameters for the push-button debouncer that
//   feeds the T flip-flop's toggle input.
//   Contents:
//     tpd_state_t        debounce FSM state encoding
//     SYNC_STAGES_DEF    default synchroniser depth
//     DB_CYCLES_DEF      default number of equal samples to accept a change
//     REPEAT_CYCLES_DEF  default auto-repeat period (T_AUTO_REPEAT_EN builds)
// ----------------------------------------------------------------------------
package t_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CONFIRM_HI = 2'd1,
    HELD       = 2'd2,
    CONFIRM_LO = 2'd3
  } tpd_state_t;

  localparam int SYNC_STAGES_DEF   = 2;
  localparam int DB_CYCLES_DEF     = 4;
  localparam int REPEAT_CYCLES_DEF = 8;

endpackage

// File: rtl/t_pulse_debounce_sync_chain.sv
// ----------------------------------------------------------------------------
// sync_chain
//   Multi-flop synchroniser that brings an asynchronous level into the clk
//   domain. All stages reset to 0.
//   Ports:
//     clk  in   clock
//     rst  in   asynchronous active-high reset
//     d    in   asynchronous input level
//     q    out  synchronised level (last stage)
// ----------------------------------------------------------------------------
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // NOTE: clocked state is always written with <= so every flop samples the
  // pre-edge value of its neighbour; blocking writes here would collapse the
  // chain into a single stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/t_pulse_debounce.sv
// ----------------------------------------------------------------------------
// t_pulse_debounce
//   Turns a raw, bouncy push-button into clean single-cycle toggle requests
//   for the downstream T flip-flop (t_out drives its t input on the same clk).
//   The input is synchronised, then a confirm-counter FSM requires DB_CYCLES
//   consecutive equal samples before accepting a level change.
//   Ports:
//     clk        in   clock, all flops on posedge
//     rst        in   asynchronous active-high reset
//     btn_in     in   raw button level, asynchronous, may bounce
//     t_out      out  registered toggle request, 1 cycle per accepted press
//     btn_level  out  registered debounced button level
//   Build option:
//     T_AUTO_REPEAT_EN  when defined, t_out also pulses every REPEAT_CYCLES
//                       cycles while the button stays held.
// ----------------------------------------------------------------------------
module t_pulse_debounce
  import t_pulse_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int DB_CYCLES     = DB_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic t_out,
  output logic btn_level
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("DB_CYCLES must be >= 1");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_rpt
    $error("REPEAT_CYCLES must be >= 2");
  end

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [DBW-1:0] DB_MAX  = DBW'(DB_CYCLES);
  localparam logic [DBW-1:0] DB_ONE  = DBW'(1);

  tpd_state_t     state, state_d;
  logic [DBW-1:0] db_cnt, db_cnt_d, db_inc;
  logic           t_out_d, btn_level_d;
  logic           sync_q;

`ifdef T_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rpt_cnt, rpt_cnt_d;
`endif

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (sync_q)
  );

  // Saturating increment: the counter parks at DB_CYCLES instead of wrapping.
  always_comb begin
    db_inc = (db_cnt == DB_MAX) ? db_cnt : db_cnt + DB_ONE;
  end

  // NOTE: every signal written here gets a default before the case, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state;
    db_cnt_d    = db_cnt;
    t_out_d     = 1'b0;
    btn_level_d = btn_level;
`ifdef T_AUTO_REPEAT_EN
    rpt_cnt_d   = rpt_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (sync_q) begin
          if (DB_CYCLES == 1) begin
            // Single-sample debounce: accept the press right away.
            state_d     = HELD;
            db_cnt_d    = '0;
            t_out_d     = 1'b1;
            btn_level_d = 1'b1;
`ifdef T_AUTO_REPEAT_EN
            rpt_cnt_d   = '0;
`endif
          end else begin
            state_d  = CONFIRM_HI;
            db_cnt_d = DB_ONE;
          end
        end
      end
      CONFIRM_HI: begin
        if (!sync_q) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt == DB_LAST) begin
          state_d     = HELD;
          db_cnt_d    = '0;
          t_out_d     = 1'b1;
          btn_level_d = 1'b1;
`ifdef T_AUTO_REPEAT_EN
          rpt_cnt_d   = '0;
`endif
        end else begin
          db_cnt_d = db_inc;
        end
      end
      HELD: begin
`ifdef T_AUTO_REPEAT_EN
        // Entry pulse was emitted on the way in; the next one lands after
        // REPEAT_CYCLES cycles spent here.
        if (rpt_cnt == RPT_LAST) begin
          t_out_d   = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt + RW'(1);
        end
`endif
        if (!sync_q) begin
          if (DB_CYCLES == 1) begin
            state_d     = IDLE;
            db_cnt_d    = '0;
            btn_level_d = 1'b0;
`ifdef T_AUTO_REPEAT_EN
            rpt_cnt_d   = '0;
`endif
          end else begin
            state_d  = CONFIRM_LO;
            db_cnt_d = DB_ONE;
          end
        end
      end
      CONFIRM_LO: begin
        // rpt_cnt is frozen here, so a bounce back to HELD keeps the phase.
        if (sync_q) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else if (db_cnt == DB_LAST) begin
          state_d     = IDLE;
          db_cnt_d    = '0;
          btn_level_d = 1'b0;
`ifdef T_AUTO_REPEAT_EN
          rpt_cnt_d   = '0;
`endif
        end else begin
          db_cnt_d = db_inc;
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      db_cnt    <= '0;
      t_out     <= 1'b0;
      btn_level <= 1'b0;
`ifdef T_AUTO_REPEAT_EN
      rpt_cnt   <= '0;
`endif
    end else begin
      state     <= state_d;
      db_cnt    <= db_cnt_d;
      t_out     <= t_out_d;
      btn_level <= btn_level_d;
`ifdef T_AUTO_REPEAT_EN
      rpt_cnt   <= rpt_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_t_pulse_debounce.sv
// ----------------------------------------------------------------------------
// tb_t_pulse_debounce
//   Directed bench for t_pulse_debounce at default parameters. A behavioural
//   model (delay line + run-length rule) predicts both outputs every cycle;
//   hand-computed literal checks pin pulse timing and counts.
//   Define T_AUTO_REPEAT_EN to exercise the auto-repeat build.
// ----------------------------------------------------------------------------
module tb_t_pulse_debounce;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int RPT  = 8;

`ifdef T_AUTO_REPEAT_EN
  localparam int T2_PULSES = 3;
`else
  localparam int T2_PULSES = 1;
`endif

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic btn_in = 1'b0;
  logic t_out;
  logic btn_level;

  int n_cmp     = 0;
  int n_fail    = 0;
  int pulse_cnt = 0;
  bit cmp_en    = 1'b0;
  bit prev_t    = 1'b0;

  always #5 clk = ~clk;

  t_pulse_debounce #(
    .SYNC_STAGES   (SYNC),
    .DB_CYCLES     (DB),
    .REPEAT_CYCLES (RPT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .t_out     (t_out),
    .btn_level (btn_level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Model: the FSM sees btn_in as sampled SYNC edges earlier. The debounced
  // level flips once DB consecutive samples disagree with it; a rise emits a
  // pulse. With auto-repeat, every REPEAT-th cycle spent settled high pulses.
  bit sq[$];
  bit m_lvl;
  int m_run;
  int m_phase;
  bit exp_t;
  bit exp_lvl;

  always @(posedge clk or posedge rst) begin : model
    bit s;
    bit pulse;
    if (rst) begin
      sq.delete();
      for (int i = 0; i < SYNC; i++) sq.push_back(1'b0);
      m_lvl   = 1'b0;
      m_run   = 0;
      m_phase = 0;
      exp_t   = 1'b0;
      exp_lvl = 1'b0;
    end else begin
      s = sq.pop_front();
      sq.push_back(btn_in);
      pulse = 1'b0;
`ifdef T_AUTO_REPEAT_EN
      if (m_lvl && m_run == 0) begin
        if (m_phase == RPT - 1) begin
          pulse   = 1'b1;
          m_phase = 0;
        end else begin
          m_phase++;
        end
      end
`endif
      if (s != m_lvl) m_run++;
      else            m_run = 0;
      if (m_run == DB) begin
        m_lvl   = !m_lvl;
        m_run   = 0;
        m_phase = 0;
        if (m_lvl) pulse = 1'b1;
      end
      exp_t   = pulse;
      exp_lvl = m_lvl;
    end
  end

  // Compare against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    #1;
    if (cmp_en) begin
      check("cyc_t_out", t_out, exp_t);
      check("cyc_btn_level", btn_level, exp_lvl);
      check("cyc_no_double_pulse", t_out && prev_t, 1'b0);
      prev_t = t_out;
      if (t_out) pulse_cnt++;
    end
  end

  // Each step ends 2 time units after the falling edge that follows a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      #2;
    end
  endtask

  initial begin
    // Test 1: reset for 3 edges, then idle low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    check("t1_reset_t_out", t_out, 1'b0);
    check("t1_reset_level", btn_level, 1'b0);
    rst    = 1'b0;
    cmp_en = 1'b1;
    step(20);
    check("t1_level_low", btn_level, 1'b0);
    check("t1_no_pulses", pulse_cnt, 0);

    // Test 2: clean press, pulse after edge 6, then clean release.
    pulse_cnt = 0;
    btn_in = 1'b1;
    step(5);
    check("t2_no_pulse_edge5", t_out, 1'b0);
    step(1);
    check("t2_pulse_edge6", t_out, 1'b1);
    check("t2_level_edge6", btn_level, 1'b1);
    step(1);
    check("t2_pulse_gone_edge7", t_out, 1'b0);
    step(17);
    check("t2_pulse_count", pulse_cnt, T2_PULSES);
    btn_in = 1'b0;
    step(5);
    check("t2_release_edge5_level", btn_level, 1'b1);
    step(1);
    check("t2_release_edge6_level", btn_level, 1'b0);
    step(6);

    // Test 3: glitchy press (2 high, 1 low, then high); pulse 6 edges after final rise.
    pulse_cnt = 0;
    btn_in = 1'b1;
    step(2);
    btn_in = 1'b0;
    step(1);
    btn_in = 1'b1;
    step(5);
    check("t3_no_pulse_edge8", t_out, 1'b0);
    step(1);
    check("t3_pulse_edge9", t_out, 1'b1);
    step(4);
    check("t3_pulse_count", pulse_cnt, 1);

    // Test 4: bouncy release from HELD; level drops 6 edges after final fall.
    pulse_cnt = 0;
    btn_in = 1'b0;
    step(2);
    btn_in = 1'b1;
    step(3);
    btn_in = 1'b0;
    step(5);
    check("t4_level_edge10", btn_level, 1'b1);
    step(1);
    check("t4_level_edge11", btn_level, 1'b0);
    step(4);
`ifndef T_AUTO_REPEAT_EN
    check("t4_no_pulses", pulse_cnt, 0);
`endif

    // Test 5: reset during CONFIRM_HI, then full latency after release.
    btn_in = 1'b1;
    step(4);
    rst = 1'b1;
    #1;
    check("t5_rst_t_out", t_out, 1'b0);
    check("t5_rst_level", btn_level, 1'b0);
    step(2);
    rst = 1'b0;
    pulse_cnt = 0;
    step(5);
    check("t5_no_pulse_edge5", t_out, 1'b0);
    step(1);
    check("t5_pulse_edge6", t_out, 1'b1);
    step(3);
    rst = 1'b1;
    #1;
    check("t5_held_rst_level", btn_level, 1'b0);
    step(1);
    btn_in = 1'b0;
    rst    = 1'b0;
    step(3);

    // Test 5b: reset asserted over the qualifying edge suppresses the pulse.
    pulse_cnt = 0;
    btn_in = 1'b1;
    step(5);
    rst = 1'b1;
    step(1);
    check("t5b_rst_wins_t_out", t_out, 1'b0);
    check("t5b_rst_wins_level", btn_level, 1'b0);
    rst    = 1'b0;
    btn_in = 1'b0;
    step(3);
    check("t5b_no_pulses", pulse_cnt, 0);

    // Test 6: long hold through edge 32.
    pulse_cnt = 0;
    btn_in = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step(1);
`ifdef T_AUTO_REPEAT_EN
      check($sformatf("t6_edge%0d", i), t_out, (i == 6 || i == 14 || i == 22 || i == 30));
`else
      check($sformatf("t6_edge%0d", i), t_out, (i == 6));
`endif
    end
    btn_in = 1'b0;
    step(15);
`ifdef T_AUTO_REPEAT_EN
    check("t6_pulse_count", pulse_cnt, 4);
`else
    check("t6_pulse_count", pulse_cnt, 1);
`endif
    check("t6_final_level", btn_level, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
